// File: rtl/bit_stream_pkg.sv
// bit_stream_pkg: shared pattern codes, FSM states and counter width for the 1-bit stream source
package bit_stream_pkg;
  localparam int CW = 11;
  typedef enum logic [1:0] {PAT_ZERO, PAT_ONE, PAT_CHECK, PAT_GRID} pattern_e;
  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_ACTIVE, S_TAIL, S_GAP} state_e;
endpackage

// File: rtl/bit_pattern_gen.sv
// bit_pattern_gen: combinational 1-bit test pattern from active pixel/line index low bits
module bit_pattern_gen
  import bit_stream_pkg::*;
(
  input  logic [2:0] x_i,
  input  logic [2:0] y_i,
  input  logic [1:0] pat_i,
  output logic       bit_o
);
  always_comb
    bit_o = pat_i == PAT_ONE   ? 1'b1 :
            pat_i == PAT_CHECK ? x_i[0] ^ y_i[0] :
            pat_i == PAT_GRID  ? (x_i == 3'd0 && y_i == 3'd0) : 1'b0;
endmodule

// File: rtl/bit_frame_generator.sv
// bit_frame_generator: frame timing FSM and registered 1-bit test-pattern video source
module bit_frame_generator
  import bit_stream_pkg::*;
#(
  parameter logic [CW-1:0] IMG_HDISP = 11'd640,
  parameter logic [CW-1:0] IMG_VDISP = 11'd480,
  parameter logic [CW-1:0] H_BLANK   = 11'd160,
  parameter logic [CW-1:0] V_LEAD    = 11'd2,
  parameter logic [CW-1:0] V_TAIL    = 11'd2,
  parameter logic [CW-1:0] V_GAP     = 11'd100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       continuous,
  input  logic [1:0] pattern_sel,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_img_Bit,
  output logic       busy,
  output logic       frame_done
);
  localparam logic [CW-1:0] LAST_X = IMG_HDISP + H_BLANK - 11'd1;
  localparam state_e FIRST = V_LEAD != 11'd0 ? S_LEAD : S_ACTIVE;
  localparam state_e AFTER = V_TAIL != 11'd0 ? S_TAIL : S_GAP;
  state_e state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [1:0] pat_q, pat_d;
  logic line_end, gap_end, href_c, pix;
  always_comb begin
    line_end = x_q == LAST_X;
    gap_end  = state_q == S_GAP && x_q == V_GAP - 11'd1;
    href_c   = state_q == S_ACTIVE && x_q < IMG_HDISP;
    pat_d    = (state_q == S_IDLE && start) || (gap_end && continuous) ? pattern_sel : pat_q;
    state_d  = state_q;
    x_d      = line_end ? '0 : x_q + 11'd1;
    y_d      = line_end ? y_q + 11'd1 : y_q;
    case (state_q)
      S_IDLE: begin
        x_d = '0;
        y_d = '0;
        if (start) state_d = FIRST;
      end
      S_LEAD: if (line_end && y_q == V_LEAD - 11'd1) begin
        state_d = S_ACTIVE;
        y_d = '0;
      end
      S_ACTIVE: if (line_end && y_q == IMG_VDISP - 11'd1) begin
        state_d = AFTER;
        y_d = '0;
      end
      S_TAIL: if (line_end && y_q == V_TAIL - 11'd1) begin
        state_d = S_GAP;
        y_d = '0;
      end
      S_GAP: begin
        // the gap reuses x as a plain cycle counter, independent of line length
        x_d = gap_end ? '0 : x_q + 11'd1;
        y_d = '0;
        if (gap_end) state_d = continuous ? FIRST : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  bit_pattern_gen u_pat (
    .x_i  (x_q[2:0]),
    .y_i  (y_q[2:0]),
    .pat_i(pat_q),
    .bit_o(pix)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q          <= S_IDLE;
      x_q              <= '0;
      y_q              <= '0;
      pat_q            <= '0;
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_img_Bit     <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
    end else begin
      state_q          <= state_d;
      x_q              <= x_d;
      y_q              <= y_d;
      pat_q            <= pat_d;
      post_frame_vsync <= state_q inside {S_LEAD, S_ACTIVE, S_TAIL};
      post_frame_href  <= href_c;
      post_img_Bit     <= href_c && pix;
      busy             <= state_q != S_IDLE && !(gap_end && !continuous);
      frame_done       <= gap_end;
    end
endmodule

// File: tb/tb_bit_frame_generator.sv
// tb_bit_frame_generator: randomized frame-timeline reference model plus directed timing checks
module tb_bit_frame_generator;
  localparam int L = 12, VS = 72, FR = 75;
  logic clk = 0, rst, start, continuous;
  logic [1:0] pattern_sel;
  logic vs, hr, pb, busy, fd;
  int n_vec = 0, n_err = 0, fd_cnt = 0;
  int t = -1, ln, col, yy;
  bit pend = 0, np, e_vs, e_hr, e_bit;
  logic [1:0] mpat = 0, ppat = 0;
  int len, fh, ones, rises, g;

  bit_frame_generator #(
    .IMG_HDISP(11'd8), .IMG_VDISP(11'd4), .H_BLANK(11'd4),
    .V_LEAD(11'd1), .V_TAIL(11'd1), .V_GAP(11'd3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .pattern_sel(pattern_sel),
    .post_frame_vsync(vs), .post_frame_href(hr), .post_img_Bit(pb), .busy(busy), .frame_done(fd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: t is the position in the output frame timeline (-1 idle), 0..71 vsync, 72..74 gap.
  always @(posedge clk or posedge rst)
    if (rst) begin
      t = -1;
      pend = 0;
    end else begin
      np = 0;
      if (pend) begin
        t = 0;
        mpat = ppat;
      end else begin
        if ((t < 0 || t == FR - 1) && start) begin np = 1; ppat = pattern_sel; end
        if (t == FR - 2 && continuous) begin np = 1; ppat = pattern_sel; end
        t = (t >= 0 && t < FR - 1) ? t + 1 : -1;
      end
      pend = np;
    end

  always @(negedge clk) begin
    ln = t / L;
    col = t % L;
    yy = ln - 1;
    e_vs = t >= 0 && t < VS;
    e_hr = e_vs && ln >= 1 && ln <= 4 && col < 8;
    e_bit = e_hr && (mpat == 1 || (mpat == 2 && (col % 2 != yy % 2)) ||
                     (mpat == 3 && col % 8 == 0 && yy % 8 == 0));
    chk("vsync", vs, e_vs);
    chk("href", hr, e_hr);
    chk("bit", pb, e_bit);
    chk("busy", busy, t >= 0 && !(t == FR - 1 && !pend));
    chk("frame_done", fd, t == FR - 1);
    fd_cnt += fd;
  end

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_vs(input logic lvl, output int n);
    n = 0;
    while (vs !== lvl && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("vsync_timeout", n, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("busy_timeout", n, 0);
    @(negedge clk);
  endtask

  task automatic frame(input bit poke, output int l, output int first, output int n1, output int nr);
    int w;
    logic prev = 0;
    wait_vs(1, w);
    l = 0; first = -1; n1 = 0; nr = 0;
    while (vs === 1'b1 && l < 400) begin
      if (first < 0 && hr) first = l;
      n1 += pb;
      nr += (hr && !prev);
      prev = hr;
      if (poke && l == 30) begin pattern_sel = 3; start = 1; end
      if (poke && l == 31) start = 0;
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    rst = 1; start = 0; continuous = 0; pattern_sel = 0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {vs, hr, pb, busy, fd}, 0);
    rst = 0;
    @(negedge clk);
    fd_cnt = 0;
    pattern_sel = 1;
    pulse_start();
    frame(0, len, fh, ones, rises);
    chk("p1_vs_len", len, 72);
    chk("p1_first_href", fh, 12);
    chk("p1_ones", ones, 32);
    chk("p1_href_pulses", rises, 4);
    wait_idle();
    chk("p1_done_cnt", fd_cnt, 1);
    pattern_sel = 2;
    pulse_start();
    frame(0, len, fh, ones, rises);
    chk("p2_ones", ones, 16);
    wait_idle();
    pattern_sel = 3;
    pulse_start();
    frame(0, len, fh, ones, rises);
    chk("p3_ones", ones, 1);
    wait_idle();
    fd_cnt = 0;
    continuous = 1;
    pattern_sel = 2'($urandom);
    pulse_start();
    frame(0, len, fh, ones, rises);
    wait_vs(1, g);
    chk("cont_period", len + g, 75);
    continuous = 0;
    frame(0, len, fh, ones, rises);
    chk("cont_f2_len", len, 72);
    wait_idle();
    repeat (20) @(negedge clk);
    chk("cont_done_cnt", fd_cnt, 2);
    chk("cont_idle", busy, 0);
    pattern_sel = 2;
    pulse_start();
    frame(1, len, fh, ones, rises);
    chk("poke_len", len, 72);
    chk("poke_ones", ones, 16);
    wait_idle();
    repeat (3000) begin
      @(negedge clk);
      start = ($urandom % 16) == 0;
      if ($urandom % 50 == 0) continuous = 1'($urandom);
      pattern_sel = 2'($urandom);
    end
    start = 0;
    continuous = 0;
    wait_idle();
    pattern_sel = 1;
    pulse_start();
    wait_vs(1, g);
    repeat (40) @(negedge clk);
    chk("pre_rst_href", hr, 1);
    #1 rst = 1;
    #1 chk("async_rst_outs", {vs, hr, pb, busy, fd}, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    pulse_start();
    frame(0, len, fh, ones, rises);
    chk("post_rst_len", len, 72);
    chk("post_rst_ones", ones, 32);
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
